// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU/mux codes, FSM states, control word.
// MC_BNE_EN adds the BNEEX state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
`ifdef MC_BNE_EN
    , S_BNEEX = 4'd12
`endif
  } state_e;

  typedef struct packed {
    logic       memtoreg;
    logic       regdst;
    logic       iord;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       pcwrite;
    logic       branch;
  } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// State-to-control-word decoder for mc_mainfsm, with write enables forced low while reset_n is low.
// MC_BNE_EN makes BNEEX decode like BEQEX.
module mc_outdec
  import mips_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  input  logic               reset_n,
  input  logic               mem_ready,
  output ctrl_t              ctrl
);

  ctrl_t ctrl_raw;

  always_comb begin
    ctrl_raw = '0;
    case (state)
      S_FETCH: begin
        ctrl_raw.alusrcb = SRCB_FOUR;
        ctrl_raw.aluop   = ALUOP_ADD;
        ctrl_raw.pcsrc   = PCSRC_ALU;
        ctrl_raw.irwrite = mem_ready;
        ctrl_raw.pcwrite = mem_ready;
      end
      S_DECODE: begin
        ctrl_raw.alusrcb = SRCB_IMMSH;
        ctrl_raw.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_raw.alusrca = 1'b1;
        ctrl_raw.alusrcb = SRCB_IMM;
        ctrl_raw.aluop   = ALUOP_ADD;
      end
      S_MEMRD: ctrl_raw.iord = 1'b1;
      S_MEMWB: begin
        ctrl_raw.regwrite = 1'b1;
        ctrl_raw.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_raw.iord     = 1'b1;
        ctrl_raw.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl_raw.alusrca = 1'b1;
        ctrl_raw.alusrcb = SRCB_B;
        ctrl_raw.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl_raw.regwrite = 1'b1;
        ctrl_raw.regdst   = 1'b1;
      end
      S_ADDIWB: ctrl_raw.regwrite = 1'b1;
`ifdef MC_BNE_EN
      S_BEQEX, S_BNEEX: begin
`else
      S_BEQEX: begin
`endif
        ctrl_raw.alusrca = 1'b1;
        ctrl_raw.alusrcb = SRCB_B;
        ctrl_raw.aluop   = ALUOP_SUB;
        ctrl_raw.pcsrc   = PCSRC_ALUOUT;
        ctrl_raw.branch  = 1'b1;
      end
      S_JEX: begin
        ctrl_raw.pcsrc   = PCSRC_JUMP;
        ctrl_raw.pcwrite = 1'b1;
      end
      default: ctrl_raw = '0;
    endcase

    ctrl = ctrl_raw;
    // Async reset already parks the state in FETCH; this also kills the mem_ready-driven strobes.
    if (!reset_n) begin
      ctrl.irwrite  = 1'b0;
      ctrl.memwrite = 1'b0;
      ctrl.regwrite = 1'b0;
      ctrl.pcwrite  = 1'b0;
      ctrl.branch   = 1'b0;
    end
  end

endmodule

// File: rtl/mc_mainfsm.sv
// Main control FSM of the multicycle MIPS: next-state logic, state register and PC enable.
// Define MC_BNE_EN to add the bne instruction (BNEEX state).
module mc_mainfsm
  import mips_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memtoreg,
  output logic       regdst,
  output logic       iord,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       pcen,
  output logic       illegal_op
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               illegal_dec;
  ctrl_t              ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = S_FETCH;
    illegal_dec = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          default: begin
            state_d     = S_FETCH;
            illegal_dec = 1'b1;
          end
        endcase
      end
      // op still holds the instruction register, so lw/sw is re-read here.
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  mc_outdec #(.STATE_W(STATE_W)) u_outdec (
    .state     (state_q),
    .reset_n   (reset_n),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  always_comb begin
    pcen = ctrl.pcwrite | (ctrl.branch & zero);
`ifdef MC_BNE_EN
    if (state_q == S_BNEEX) pcen = ctrl.branch & ~zero;
`endif
  end

  assign memtoreg   = ctrl.memtoreg;
  assign regdst     = ctrl.regdst;
  assign iord       = ctrl.iord;
  assign pcsrc      = ctrl.pcsrc;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign aluop      = ctrl.aluop;
  assign irwrite    = ctrl.irwrite;
  assign memwrite   = ctrl.memwrite;
  assign regwrite   = ctrl.regwrite;
  assign illegal_op = illegal_dec & reset_n;

endmodule

// File: tb/tb_mc_mainfsm.sv
// Scoreboard bench for mc_mainfsm: a driver issues random instructions and queues the expected per-cycle
// control outputs from an instruction-level model; a monitor compares them on the falling edge.
module tb_mc_mainfsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       memtoreg, regdst, iord, alusrca, irwrite, memwrite, regwrite, pcen, illegal_op;
  logic [1:0] pcsrc, alusrcb, aluop;

  typedef struct packed {
    logic       memtoreg;
    logic       regdst;
    logic       iord;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       pcen;
    logic       illegal_op;
  } obs_t;

  typedef enum {
    P_RESET, P_FETCH, P_DECODE, P_DECILL, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
    P_RTEX, P_RTWB, P_ADDIEX, P_ADDIWB, P_BEQ, P_BNE, P_J
  } phase_e;

  obs_t   expq[$];
  string  nameq[$];
  phase_e plan_q[$];
  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;

  mc_mainfsm #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .iord       (iord),
    .pcsrc      (pcsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .aluop      (aluop),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .pcen       (pcen),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  // Expected outputs of one cycle, straight from the per-state output table.
  function automatic obs_t model(input phase_e p, input logic rdy, input logic z);
    obs_t o;
    o = '0;
    case (p)
      P_RESET:  o.alusrcb = 2'b01;
      P_FETCH:  begin o.alusrcb = 2'b01; o.irwrite = rdy; o.pcen = rdy; end
      P_DECODE: o.alusrcb = 2'b11;
      P_DECILL: begin o.alusrcb = 2'b11; o.illegal_op = 1'b1; end
      P_MEMADR, P_ADDIEX: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
      P_MEMRD:  o.iord = 1'b1;
      P_MEMWB:  begin o.regwrite = 1'b1; o.memtoreg = 1'b1; end
      P_MEMWR:  begin o.iord = 1'b1; o.memwrite = 1'b1; end
      P_RTEX:   begin o.alusrca = 1'b1; o.aluop = 2'b11; end
      P_RTWB:   begin o.regwrite = 1'b1; o.regdst = 1'b1; end
      P_ADDIWB: o.regwrite = 1'b1;
      P_BEQ:    begin o.alusrca = 1'b1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.pcen = z; end
      P_BNE:    begin o.alusrca = 1'b1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.pcen = ~z; end
      P_J:      begin o.pcsrc = 2'b10; o.pcen = 1'b1; end
      default:  o = '0;
    endcase
    return o;
  endfunction

  function automatic bit is_mem(input phase_e p);
    return (p == P_FETCH) || (p == P_MEMRD) || (p == P_MEMWR);
  endfunction

  // Sequence of states an instruction walks through, by opcode.
  task automatic make_plan(input logic [5:0] o);
    plan_q.delete();
    plan_q.push_back(P_FETCH);
    case (o)
      6'b100011: begin plan_q.push_back(P_DECODE); plan_q.push_back(P_MEMADR);
                       plan_q.push_back(P_MEMRD); plan_q.push_back(P_MEMWB); end
      6'b101011: begin plan_q.push_back(P_DECODE); plan_q.push_back(P_MEMADR);
                       plan_q.push_back(P_MEMWR); end
      6'b000000: begin plan_q.push_back(P_DECODE); plan_q.push_back(P_RTEX); plan_q.push_back(P_RTWB); end
      6'b001000: begin plan_q.push_back(P_DECODE); plan_q.push_back(P_ADDIEX); plan_q.push_back(P_ADDIWB); end
      6'b000100: begin plan_q.push_back(P_DECODE); plan_q.push_back(P_BEQ); end
      6'b000010: begin plan_q.push_back(P_DECODE); plan_q.push_back(P_J); end
`ifdef MC_BNE_EN
      6'b000101: begin plan_q.push_back(P_DECODE); plan_q.push_back(P_BNE); end
`endif
      default:   plan_q.push_back(P_DECILL);
    endcase
  endtask

  task automatic step(input logic rst, input logic [5:0] o, input logic rdy, input logic z, input phase_e p);
    @(posedge clk);
    #1;
    reset_n   = ~rst;
    op        = o;
    mem_ready = rdy;
    zero      = z;
    expq.push_back(model(p, rdy, z));
    nameq.push_back(p.name());
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 6'b000000, 1'b1, 1'($urandom_range(0, 1)), P_RESET);
  endtask

  // fw/mw < 0 picks a random number of mem_ready-low cycles per memory state.
  task automatic run_instr(input logic [5:0] o, input int fw, input int mw, input int zsel);
    int   waits;
    logic rdy, z;
    make_plan(o);
    foreach (plan_q[k]) begin
      if (plan_q[k] == P_FETCH) waits = (fw < 0) ? $urandom_range(0, 2) : fw;
      else if (is_mem(plan_q[k])) waits = (mw < 0) ? $urandom_range(0, 2) : mw;
      else waits = 0;
      for (int w = 0; w <= waits; w++) begin
        if (is_mem(plan_q[k])) rdy = (w == waits);
        else rdy = 1'($urandom_range(0, 1));
        z = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
        step(1'b0, o, rdy, z, plan_q[k]);
      end
    end
  endtask

  initial begin : monitor
    obs_t  e, a;
    string n;
    forever begin
      @(negedge clk);
      cyc++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        n = nameq.pop_front();
        a = {memtoreg, regdst, iord, pcsrc, alusrca, alusrcb, aluop,
             irwrite, memwrite, regwrite, pcen, illegal_op};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL %s cycle %0d: got %b required %b", n, cyc, a, e);
        end
      end
    end
  end

  initial begin : driver
    logic [5:0] rop;
    reset_n   = 1'b0;
    op        = 6'b000000;
    zero      = 1'b0;
    mem_ready = 1'b1;
    reset_cycles(2);

    run_instr(6'b100011, 0, 0, -1);
    run_instr(6'b000000, 0, 0, -1);
    run_instr(6'b000100, 0, 0, 1);
    run_instr(6'b000100, 0, 0, 0);
    run_instr(6'b101011, 0, 3, -1);
    run_instr(6'b000101, 0, 0, 1);
    run_instr(6'b000101, 0, 0, 0);
    run_instr(6'b000010, 0, 0, -1);
    run_instr(6'b001000, 0, 0, -1);
    run_instr(6'b111111, 0, 0, -1);

    // Reset taken while the FSM sits in RTYPEEX, then with mem_ready high in FETCH.
    step(1'b0, 6'b000000, 1'b1, 1'b0, P_FETCH);
    step(1'b0, 6'b000000, 1'b1, 1'b0, P_DECODE);
    reset_cycles(3);
    run_instr(6'b100011, 2, 2, -1);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0: rop = 6'b100011;
        1: rop = 6'b101011;
        2: rop = 6'b000000;
        3: rop = 6'b000100;
        4: rop = 6'b001000;
        5: rop = 6'b000010;
        6: rop = 6'b000101;
        default: rop = 6'($urandom());
      endcase
      run_instr(rop, -1, -1, -1);
      if ($urandom_range(0, 19) == 0) reset_cycles(1);
    end

    for (int i = 0; i < 5 && expq.size() > 0; i++) @(negedge clk);
    #1;
    if (expq.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
